// File: rtl/hs_pkg.sv
// Shared handshake-arbiter definitions: FSM state encoding and the
// index-width helper used to size requester indices.
package hs_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdyval_rr_arbiter_rr_pick.sv
// Rotating-priority picker: selects the first asserted request at or after
// ptr, wrapping past N-1 back to 0.
module rr_pick
  import hs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] idx,
  output logic                any
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // walk candidates in priority order; only the first hit is recorded
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s      = IW'((int'(ptr) + i) % N);
      hit_s       = req[cand_s] & ~any;
      gnt[cand_s] = gnt[cand_s] | hit_s;
      idx         = hit_s ? cand_s : idx;
      any         = any | hit_s;
    end
  end

endmodule

// File: rtl/rdyval_rr_arbiter.sv
// Packet-aware round-robin merge of N rdy/vld streams into one registered
// output stage; a channel keeps the grant from its first beat until i_last.
module rdyval_rr_arbiter
  import hs_pkg::*;
#(
  parameter int N      = 4,
  parameter int DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           i_vld,
  output logic [N-1:0]           i_rdy,
  input  logic [N*DWIDTH-1:0]    i_dat,
  input  logic [N-1:0]           i_last,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [DWIDTH-1:0]      o_dat,
  output logic                   o_last,
  output logic [idx_w(N)-1:0]    o_src
);

  localparam int            IW       = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    return (cur == LAST_IDX) ? IW'(0) : cur + IW'(1);
  endfunction

  arb_state_e        state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     lock_idx_r;

  logic              load_en_s;
  logic              xfer_s;
  logic [N-1:0]      grant_s;
  logic [N-1:0]      rdy_s;
  logic [IW-1:0]     win_idx_s;
  logic [DWIDTH-1:0] win_dat_s;
  logic              win_last_s;
  logic [N-1:0]      pick_gnt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_any_s;

  assign load_en_s = ~o_vld | o_rdy;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req (i_vld),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // grant follows the rotating pick when idle, pinned to lock_idx otherwise
  always_comb begin
    grant_s   = '0;
    win_idx_s = '0;
    case (state_r)
      ARB_IDLE: begin
        grant_s   = pick_any_s ? pick_gnt_s : '0;
        win_idx_s = pick_idx_s;
      end
      ARB_LOCKED: begin
        grant_s[lock_idx_r] = 1'b1;
        win_idx_s           = lock_idx_r;
      end
      default: begin
        grant_s   = '0;
        win_idx_s = '0;
      end
    endcase
  end

  // ready is masked during reset so no upstream beat is consumed then
  assign rdy_s  = (load_en_s & ~rst) ? grant_s : '0;
  assign i_rdy  = rdy_s;
  assign xfer_s = |(rdy_s & i_vld);

  // one-hot mux of the granted channel's payload
  always_comb begin
    win_dat_s  = '0;
    win_last_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      win_dat_s  = win_dat_s | ({DWIDTH{grant_s[k]}} & i_dat[k*DWIDTH +: DWIDTH]);
      win_last_s = win_last_s | (grant_s[k] & i_last[k]);
    end
  end

  // output register stage plus packet-lock FSM and rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld      <= 1'b0;
      o_dat      <= '0;
      o_last     <= 1'b0;
      o_src      <= '0;
      state_r    <= ARB_IDLE;
      ptr_r      <= '0;
      lock_idx_r <= '0;
    end else begin
      if (load_en_s) begin
        o_vld <= xfer_s;
        if (xfer_s) begin
          o_dat  <= win_dat_s;
          o_last <= win_last_s;
          o_src  <= win_idx_s;
        end
      end
      if (xfer_s) begin
        case (state_r)
          ARB_IDLE: begin
            if (win_last_s) begin
              ptr_r <= next_idx(win_idx_s);
            end else begin
              state_r    <= ARB_LOCKED;
              lock_idx_r <= win_idx_s;
            end
          end
          ARB_LOCKED: begin
            if (win_last_s) begin
              state_r <= ARB_IDLE;
              ptr_r   <= next_idx(lock_idx_r);
            end
          end
          default: begin
            state_r <= ARB_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rdyval_rr_arbiter.sv
// Bench for rdyval_rr_arbiter: directed scenarios plus a randomized run
// against a behavioural round-robin packet model.
module tb_rdyval_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_vld;
  logic [N-1:0]    i_rdy;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_last;
  logic            o_vld;
  logic            o_rdy;
  logic [DW-1:0]   o_dat;
  logic            o_last;
  logic [1:0]      o_src;

  always #5 clk = ~clk;

  rdyval_rr_arbiter #(.N(N), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat), .i_last(i_last),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_last(o_last), .o_src(o_src)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: lock = -1 when no packet is open
  int          m_lock, m_ptr, m_win, m_os;
  bit          m_ov, m_ol, m_load, m_xfer;
  logic [31:0] m_od;
  logic [N-1:0] m_rdy;
  int          bc [N];
  logic [N-1:0] obs;

  function automatic logic [31:0] dat_of(input int k, input int n);
    return {8'(k), 24'(n)};
  endfunction

  function automatic void model_reset();
    m_lock = -1; m_ptr = 0; m_ov = 1'b0; m_ol = 1'b0; m_od = 32'h0; m_os = 0;
  endfunction

  function automatic void model_comb();
    m_load = !m_ov || o_rdy;
    m_win  = -1;
    if (m_lock >= 0) m_win = m_lock;
    else
      for (int j = 0; j < N; j++)
        if (m_win < 0 && i_vld[(m_ptr + j) % N]) m_win = (m_ptr + j) % N;
    m_rdy = '0;
    if (m_load && m_win >= 0) m_rdy[m_win] = 1'b1;
    m_xfer = m_load && (m_win >= 0) && i_vld[m_win];
  endfunction

  function automatic void model_seq();
    if (m_load) begin
      m_ov = m_xfer;
      if (m_xfer) begin
        m_od = i_dat[m_win*DW +: DW]; m_ol = i_last[m_win]; m_os = m_win;
      end
    end
    if (m_xfer) begin
      if (i_last[m_win]) begin m_lock = -1; m_ptr = (m_win + 1) % N; end
      else m_lock = m_win;
    end
  endfunction

  task automatic set_in(input logic [N-1:0] vld, input logic [N-1:0] last);
    i_vld = vld; i_last = last;
    for (int k = 0; k < N; k++) i_dat[k*DW +: DW] = dat_of(k, bc[k]);
  endtask

  task automatic settle();
    #1; model_comb();
  endtask

  task automatic tick();
    obs = i_vld & i_rdy;
    @(posedge clk);
    if (rst) model_reset(); else model_seq();
    for (int k = 0; k < N; k++) if (obs[k]) bc[k] = bc[k] + 1;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) bc[k] = 0;
    o_rdy = 1'b1; set_in(4'b1111, 4'b1111);
    rst = 1'b0; #1; rst = 1'b1; #1;
    model_reset();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_o_vld: got %b want 0", o_vld); end
    checks++; if (o_dat !== 32'h0) begin errors++; $display("FAIL reset_o_dat: got %h want 0", o_dat); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last: got %b want 0", o_last); end
    checks++; if (o_src !== 2'd0) begin errors++; $display("FAIL reset_o_src: got %0d want 0", o_src); end
    checks++; if (i_rdy !== 4'b0000) begin errors++; $display("FAIL reset_i_rdy: got %b want 0000", i_rdy); end
    tick(); tick();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 4'b0000) begin
      errors++; $display("FAIL reset_hold: got o_vld=%b i_rdy=%b want 0/0000", o_vld, i_rdy);
    end
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    int exp_src [5] = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      set_in(4'b1111, 4'b1111); settle();
      checks++; if (i_rdy !== m_rdy) begin errors++; $display("FAIL rr_i_rdy[%0d]: got %b want %b", c, i_rdy, m_rdy); end
      tick();
      checks++; if (o_vld !== 1'b1 || o_src !== 2'(exp_src[c])) begin
        errors++; $display("FAIL rr_src[%0d]: got vld=%b src=%0d want 1/%0d", c, o_vld, o_src, exp_src[c]);
      end
      checks++; if (o_dat !== m_od) begin errors++; $display("FAIL rr_dat[%0d]: got %h want %h", c, o_dat, m_od); end
    end
  endtask

  task automatic test_pkt_lock();
    int   exp_src [4] = '{1, 1, 1, 2};
    logic exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    set_in(4'b0000, 4'b0000); settle(); tick();
    for (int s = 0; s < 4; s++) begin
      set_in(4'b0111, {1'b0, 1'b1, (s == 2), 1'b1}); settle();
      checks++; if (i_rdy !== m_rdy) begin errors++; $display("FAIL lock_i_rdy[%0d]: got %b want %b", s, i_rdy, m_rdy); end
      tick();
      checks++; if (o_vld !== 1'b1 || o_src !== 2'(exp_src[s]) || o_last !== exp_last[s]) begin
        errors++; $display("FAIL lock_out[%0d]: got vld=%b src=%0d last=%b want 1/%0d/%b",
                           s, o_vld, o_src, o_last, exp_src[s], exp_last[s]);
      end
    end
  endtask

  task automatic test_pkt_gap();
    logic [3:0] vt [5] = '{4'b1001, 4'b0001, 4'b0001, 4'b1001, 4'b0001};
    logic [3:0] lt [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
    logic [3:0] rt [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic       ov [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         sr [5] = '{3, 0, 0, 3, 0};
    set_in(4'b0000, 4'b0000); settle(); tick();
    for (int s = 0; s < 5; s++) begin
      set_in(vt[s], lt[s]); settle();
      checks++; if (i_rdy !== rt[s]) begin errors++; $display("FAIL gap_i_rdy[%0d]: got %b want %b", s, i_rdy, rt[s]); end
      tick();
      checks++; if (o_vld !== ov[s] || (ov[s] && o_src !== 2'(sr[s]))) begin
        errors++; $display("FAIL gap_out[%0d]: got vld=%b src=%0d want %b/%0d", s, o_vld, o_src, ov[s], sr[s]);
      end
    end
  endtask

  task automatic test_stall();
    o_rdy = 1'b1;
    set_in(4'b0010, 4'b0010); i_dat[1*DW +: DW] = 32'hDEADBEEF; settle(); tick();
    checks++; if (o_vld !== 1'b1 || o_dat !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stall_load: got vld=%b dat=%h want 1/deadbeef", o_vld, o_dat);
    end
    o_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      set_in(4'b0110, 4'b0110); settle();
      checks++; if (i_rdy !== 4'b0000) begin errors++; $display("FAIL stall_i_rdy[%0d]: got %b want 0000", s, i_rdy); end
      tick();
      checks++; if (o_vld !== 1'b1 || o_dat !== 32'hDEADBEEF) begin
        errors++; $display("FAIL stall_hold[%0d]: got vld=%b dat=%h want 1/deadbeef", s, o_vld, o_dat);
      end
    end
    o_rdy = 1'b1;
    set_in(4'b0110, 4'b0110); settle();
    checks++; if (i_rdy !== 4'b0100) begin errors++; $display("FAIL stall_resume_rdy: got %b want 0100", i_rdy); end
    tick();
    checks++; if (o_vld !== 1'b1 || o_src !== 2'd2 || o_dat !== m_od) begin
      errors++; $display("FAIL stall_resume_out: got src=%0d dat=%h want 2/%h", o_src, o_dat, m_od);
    end
    set_in(4'b0010, 4'b0010); settle();
    checks++; if (i_rdy !== 4'b0010) begin errors++; $display("FAIL stall_ch1_rdy: got %b want 0010", i_rdy); end
    tick();
    checks++; if (o_vld !== 1'b1 || o_src !== 2'd1 || o_dat !== dat_of(1, bc[1] - 1)) begin
      errors++; $display("FAIL stall_ch1_out: got src=%0d dat=%h want 1/%h", o_src, o_dat, dat_of(1, bc[1] - 1));
    end
  endtask

  task automatic test_rst_mid();
    o_rdy = 1'b1;
    set_in(4'b0100, 4'b0000); settle(); tick();
    checks++; if (o_vld !== 1'b1 || o_src !== 2'd2) begin
      errors++; $display("FAIL rstmid_lock: got vld=%b src=%0d want 1/2", o_vld, o_src);
    end
    set_in(4'b1111, 4'b0000); settle();
    checks++; if (i_rdy !== 4'b0100) begin errors++; $display("FAIL rstmid_locked_rdy: got %b want 0100", i_rdy); end
    rst = 1'b1; #1; model_reset();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 4'b0000) begin
      errors++; $display("FAIL rstmid_during: got vld=%b rdy=%b want 0/0000", o_vld, i_rdy);
    end
    tick();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 4'b0000) begin
      errors++; $display("FAIL rstmid_held: got vld=%b rdy=%b want 0/0000", o_vld, i_rdy);
    end
    rst = 1'b0;
    set_in(4'b0110, 4'b0110); settle();
    checks++; if (i_rdy !== 4'b0010 || i_rdy !== m_rdy) begin
      errors++; $display("FAIL rstmid_first_rdy: got %b want 0010", i_rdy);
    end
    tick();
    checks++; if (o_vld !== 1'b1 || o_src !== 2'd1) begin
      errors++; $display("FAIL rstmid_first_out: got vld=%b src=%0d want 1/1", o_vld, o_src);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] nv, nl, x;
    int           wait_pk [N];
    int           open_src;
    open_src = -1;
    for (int k = 0; k < N; k++) wait_pk[k] = 0;
    nv = i_vld; nl = i_last;
    for (int c = 0; c < 10000; c++) begin
      o_rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++)
        if (!nv[k] || obs[k]) begin
          nv[k] = ($urandom_range(0, 2) != 0);
          nl[k] = ($urandom_range(0, 2) == 0);
        end
      set_in(nv, nl); settle();
      checks++; if (i_rdy !== m_rdy) begin errors++; $display("FAIL rnd_i_rdy[%0d]: got %b want %b", c, i_rdy, m_rdy); end
      if (o_vld && o_rdy) begin
        checks++; if (open_src >= 0 && int'(o_src) != open_src) begin
          errors++; $display("FAIL rnd_interleave[%0d]: got src %0d want %0d", c, o_src, open_src);
        end
        open_src = o_last ? -1 : int'(o_src);
      end
      x = i_vld & i_rdy;
      for (int j = 0; j < N; j++)
        if (x[j] && i_last[j])
          for (int k = 0; k < N; k++)
            if (k != j && i_vld[k]) begin
              wait_pk[k]++;
              checks++; if (wait_pk[k] > N) begin
                errors++; $display("FAIL rnd_starve[%0d]: ch%0d waited %0d packets want <= %0d", c, k, wait_pk[k], N);
              end
            end
      for (int k = 0; k < N; k++) if (x[k]) wait_pk[k] = 0;
      tick();
      checks++; if (o_vld !== m_ov) begin errors++; $display("FAIL rnd_o_vld[%0d]: got %b want %b", c, o_vld, m_ov); end
      if (m_ov) begin
        checks++; if (o_dat !== m_od || int'(o_src) != m_os || o_last !== m_ol) begin
          errors++; $display("FAIL rnd_beat[%0d]: got %h/%0d/%b want %h/%0d/%b", c, o_dat, o_src, o_last, m_od, m_os, m_ol);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_pkt_lock();
    test_pkt_gap();
    test_stall();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rdyval_rr_arbiter.md
RDYVAL_RR_ARBITER -- requirements
Module: rdyval_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of rdy/vld requester channels (2..16).
REQ-002 Parameter DWIDTH, default 32, data width per channel.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_vld  input  N  per-requester valid.
REQ-006 i_rdy  output  N  per-requester ready; beat k transfers when i_vld[k]&i_rdy[k].
REQ-007 i_dat  input  N*DWIDTH  per-requester data; slice k is bits [k*DWIDTH +: DWIDTH].
REQ-008 i_last  input  N  per-requester end-of-packet marker.
REQ-009 o_vld  output  1  merged output valid.
REQ-010 o_rdy  input  1  downstream ready; output beat transfers when o_vld&o_rdy.
REQ-011 o_dat  output  DWIDTH  merged output data.
REQ-012 o_last  output  1  end-of-packet of current output beat.
REQ-013 o_src  output  clog2(N)  index of requester that supplied the current output beat.

Function
REQ-014 Output path SHALL be one registered stage: load_en = !o_vld | o_rdy; latency from input transfer to o_vld = 1 cycle; full throughput of 1 beat/cycle.
REQ-015 o_vld/o_dat/o_last/o_src SHALL load on load_en & (any granted transfer); o_vld SHALL clear on o_rdy when no new beat loads.
REQ-016 At most one i_rdy bit SHALL be high per cycle; i_rdy[k] = load_en & grant[k].
REQ-017 FSM states IDLE and LOCKED; reset state IDLE.
REQ-018 IDLE: grant SHALL go to the first k with i_vld[k]=1 searching k = ptr, ptr+1, ... mod N; no i_vld -> no grant, i_rdy=0.
REQ-019 IDLE, granted transfer with i_last=0 -> LOCKED, lock_idx = winner.
REQ-020 IDLE, granted transfer with i_last=1 -> stay IDLE, ptr = (winner+1) mod N.
REQ-021 LOCKED: grant SHALL be lock_idx only, independent of other i_vld; i_rdy[lock_idx]=load_en even while i_vld[lock_idx]=0 (packet gap), no other channel served.
REQ-022 LOCKED, transfer with i_last=1 -> IDLE, ptr = (lock_idx+1) mod N; i_last=0 -> stay LOCKED.
REQ-023 ptr SHALL change only at packet end; wrap from N-1 to 0.
REQ-024 Grant decision SHALL be combinational from current state/ptr/i_vld; requester dropping i_vld before transfer (protocol violation) SHALL not corrupt state (no transfer, no update).
REQ-025 o_rdy held low SHALL stall: o_* stable, all i_rdy=0, FSM/ptr unchanged.
REQ-026 Simultaneous output drain and new load in same cycle SHALL keep o_vld=1 with new beat.

Reset
REQ-027 While rst=1: o_vld=0, o_dat=0, o_last=0, o_src=0, i_rdy=0, state=IDLE, ptr=0, lock_idx=0.
REQ-028 rst asserted mid-packet SHALL discard output beat and lock immediately; after release arbitration restarts from ptr=0.

Structure
REQ-029 Shared package hs_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_LOCKED) and the index-width helper function.
REQ-030 Rotating-priority selection SHALL be a sub-module rr_pick (inputs req N, ptr; outputs one-hot gnt, idx, any).

Verification (N=4, DWIDTH=32)
REQ-031 All i_vld=1, i_last=1, o_rdy=1 continuously -> o_src sequence 0,1,2,3,0 on consecutive cycles, first o_vld one cycle after reset release.
REQ-032 Ch1 sends 3-beat packet (last on beat 3) while ch0/ch2 valid -> o_src=1,1,1 uninterrupted, then next grant ch2.
REQ-033 Ch3 packet with 2-cycle i_vld gap mid-packet, ch0 valid -> no ch0 beat until ch3 i_last beat transfers; then o_src=0.
REQ-034 o_rdy=0 for 5 cycles with o_vld=1, o_dat=0xDEADBEEF -> o_dat stable, i_rdy=0 throughout, no beat lost after o_rdy=1.
REQ-035 rst pulsed during LOCKED on ch2 -> o_vld=0, i_rdy=0 during reset; first post-reset grant to lowest valid index from 0.
REQ-036 Random i_vld/i_last/o_rdy, 10k cycles -> scoreboard: per-source order preserved, packets never interleaved, no starvation beyond N packets.
